frac_norm: RTL and testbench

Post-add normalizer for the 9-bit minifloat datapath (1 sign, 4-bit biased exponent, 4-bit fraction with hidden 1). It is the back end of the adder whose front end orders and aligns the operand fractions. It accepts the raw mantissa sum and common exponent, then normalizes iteratively, one shift per clock. Results leave through a valid/ready handshake as a packed sign/exponent/fraction with overflow, underflow and zero flags.

---
 rtl/fp_pkg.sv | 16 +
 rtl/fp_norm_step.sv | 63 ++++++
 rtl/frac_norm.sv | 114 +++++++++++
 tb/tb_frac_norm.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants and types for the 9-bit minifloat datapath.
package fp_pkg;

    localparam int EXP_W    = 4;
    localparam int FRAC_W   = 4;
    localparam int EXP_BIAS = 7;
    localparam int EXP_INF  = 15;
    localparam int EXP_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_t;

endpackage

// File: rtl/fp_norm_step.sv
// One normalization step: given the working mantissa and exponent, produce
// the next pair plus a done flag and the result classification flags.
module fp_norm_step #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
) (
    input  logic [FRAC_W+1:0] m,
    input  logic [EXP_W-1:0]  e,
    output logic [FRAC_W+1:0] m_next,
    output logic [EXP_W-1:0]  e_next,
    output logic              done,
    output logic              zero,
    output logic              ovf,
    output logic              unf
);

    localparam int MW = FRAC_W + 2;
    // All-ones exponent (infinity), extended by one bit for the carry compare.
    localparam logic [EXP_W:0] INF_EXT = {1'b0, {EXP_W{1'b1}}};

    logic [EXP_W:0] e_inc;

    assign e_inc = {1'b0, e} + (EXP_W+1)'(1);

    // Priority-ordered step rules: zero, carry, normalized, left shift / flush.
    always_comb begin
        m_next = m;
        e_next = e;
        done   = 1'b0;
        zero   = 1'b0;
        ovf    = 1'b0;
        unf    = 1'b0;
        if (e == '0 || m == '0) begin
            done   = 1'b1;
            zero   = 1'b1;
            unf    = (e == '0) && (m != '0);
            m_next = '0;
            e_next = '0;
        end else if (m[MW-1]) begin
            done   = 1'b1;
            m_next = m >> 1;
            e_next = e_inc[EXP_W-1:0];
            // Saturate on reaching the reserved exponent: infinity, fraction 0.
            if (e_inc >= INF_EXT) begin
                ovf    = 1'b1;
                e_next = '1;
                m_next = {2'b01, {FRAC_W{1'b0}}};
            end
        end else if (m[MW-2]) begin
            done = 1'b1;
        end else if (e == EXP_W'(1)) begin
            done   = 1'b1;
            zero   = 1'b1;
            unf    = 1'b1;
            m_next = '0;
            e_next = '0;
        end else begin
            m_next = m << 1;
            e_next = e - EXP_W'(1);
        end
    end

endmodule

// File: rtl/frac_norm.sv
// Post-add normalizer: accepts a raw mantissa sum and common exponent,
// normalizes one shift per clock and returns the packed result via valid/ready.
module frac_norm
    import fp_pkg::*;
#(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W+1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_zero
);

    norm_state_t state, state_next;

    logic              sign_r;
    logic [FRAC_W+1:0] m_r;
    logic [EXP_W-1:0]  e_r;

    logic [FRAC_W+1:0] step_m;
    logic [EXP_W-1:0]  step_e;
    logic              step_done;
    logic              step_zero;
    logic              step_ovf;
    logic              step_unf;

    fp_norm_step #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_step (
        .m      (m_r),
        .e      (e_r),
        .m_next (step_m),
        .e_next (step_e),
        .done   (step_done),
        .zero   (step_zero),
        .ovf    (step_ovf),
        .unf    (step_unf)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, iterate until the step reports done, hand off.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = NORM;
            NORM:    if (step_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working registers and result registers; results load only on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r   <= 1'b0;
            m_r      <= '0;
            e_r      <= '0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_frac <= '0;
            out_ovf  <= 1'b0;
            out_unf  <= 1'b0;
            out_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_sign;
                        m_r    <= in_mant;
                        e_r    <= in_exp;
                    end
                end
                NORM: begin
                    m_r <= step_m;
                    e_r <= step_e;
                    if (step_done) begin
                        out_sign <= sign_r & ~step_zero;
                        out_exp  <= step_e;
                        out_frac <= step_m[FRAC_W-1:0];
                        out_ovf  <= step_ovf;
                        out_unf  <= step_unf;
                        out_zero <= step_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frac_norm.sv
// Self-checking bench for frac_norm: vector table plus handshake/reset sequences.
module tb_frac_norm;

    localparam int EW = 4;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [EW-1:0] in_exp;
    logic [FW+1:0] in_mant;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [FW-1:0] out_frac;
    logic          out_ovf;
    logic          out_unf;
    logic          out_zero;

    always #5 clk = ~clk;

    frac_norm #(.EXP_W(EW), .FRAC_W(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_zero  (out_zero)
    );

    // res = {sign, exp[3:0], frac[3:0], ovf, unf, zero}
    typedef struct {
        logic        s;
        logic [3:0]  e;
        logic [5:0]  m;
        logic [11:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [11:0] res;
        int          lat;
    } exp_t;

    exp_t scb[$];
    vec_t vecs[14];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic s, logic [3:0] e, logic [5:0] m,
                                logic os, logic [3:0] oe, logic [3:0] of,
                                logic ov, logic un, logic z, int lat);
        vec_t v;
        v.s   = s;
        v.e   = e;
        v.m   = m;
        v.res = {os, oe, of, ov, un, z};
        v.lat = lat;
        return v;
    endfunction

    function automatic logic [11:0] got();
        return {out_sign, out_exp, out_frac, out_ovf, out_unf, out_zero};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Offer one input for a single accept cycle, then scramble the inputs.
    task automatic send(input vec_t v, input bit push);
        exp_t x;
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sign  = v.s;
        in_exp   = v.e;
        in_mant  = v.m;
        if (push) begin
            x.res = v.res;
            x.lat = v.lat;
            scb.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sign  = ~v.s;
        in_exp   = ~v.e;
        in_mant  = ~v.m;
    endtask

    // Wait (bounded) for out_valid, then compare latency and result with the scoreboard.
    task automatic collect(input string name);
        int   lat = 0;
        exp_t x;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check({name, "_timeout"}, 32'(out_valid), 32'd1);
        x = scb.pop_front();
        check({name, "_lat"}, 32'(lat), 32'(x.lat));
        check({name, "_res"}, 32'(got()), 32'(x.res));
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        //            s  e      m          os  oe     of      ov  un  z  lat
        vecs[0]  = mk(0, 4'd5,  6'b101100, 0, 4'd6,  4'b0110, 0, 0, 0, 1); // carry
        vecs[1]  = mk(0, 4'd6,  6'b000011, 0, 4'd3,  4'b1000, 0, 0, 0, 4); // three shifts
        vecs[2]  = mk(1, 4'd14, 6'b100000, 1, 4'd15, 4'b0000, 1, 0, 0, 1); // overflow
        vecs[3]  = mk(1, 4'd2,  6'b000100, 0, 4'd0,  4'b0000, 0, 1, 1, 2); // underflow
        vecs[4]  = mk(1, 4'd9,  6'b000000, 0, 4'd0,  4'b0000, 0, 0, 1, 1); // zero
        vecs[5]  = mk(1, 4'd7,  6'b011011, 1, 4'd7,  4'b1011, 0, 0, 0, 1); // normalized
        vecs[6]  = mk(0, 4'd0,  6'b010000, 0, 4'd0,  4'b0000, 0, 1, 1, 1); // exp 0, nonzero
        vecs[7]  = mk(0, 4'd4,  6'b001111, 0, 4'd3,  4'b1110, 0, 0, 0, 2); // one shift
        vecs[8]  = mk(1, 4'd3,  6'b111111, 1, 4'd4,  4'b1111, 0, 0, 0, 1); // carry truncation
        vecs[9]  = mk(0, 4'd3,  6'b000100, 0, 4'd1,  4'b0000, 0, 0, 0, 3); // lands on exp 1
        vecs[10] = mk(0, 4'd2,  6'b000010, 0, 4'd0,  4'b0000, 0, 1, 1, 2); // flush after shift
        vecs[11] = mk(1, 4'd1,  6'b001000, 0, 4'd0,  4'b0000, 0, 1, 1, 1); // flush at exp 1
        vecs[12] = mk(0, 4'd14, 6'b110000, 0, 4'd15, 4'b0000, 1, 0, 0, 1); // overflow, nonzero low bits
        vecs[13] = mk(0, 4'd13, 6'b100010, 0, 4'd14, 4'b0001, 0, 0, 0, 1); // carry to max finite

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs",   32'(got()),     32'd0);

        for (int i = 0; i < 14; i++) begin
            send(vecs[i], 1'b1);
            collect($sformatf("vec%0d", i));
            release_out($sformatf("vec%0d", i));
        end

        // Result held with out_ready low for five cycles while new input is offered.
        send(vecs[1], 1'b1);
        collect("hold");
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_mant = 6'(k);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d_ready", k), 32'(in_ready),  32'd0);
            check($sformatf("hold%0d_res", k),   32'(got()),     32'(vecs[1].res));
        end
        in_valid = 1'b0;
        release_out("hold");

        // out_ready already high on entering DONE: one-cycle handshake.
        out_ready = 1'b1;
        send(vecs[0], 1'b1);
        collect("early_ready");
        @(posedge clk);
        #1;
        check("early_ready_idle",  32'(in_ready),  32'd1);
        check("early_ready_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset mid-normalization aborts without emitting a result.
        send(vecs[1], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_outputs",   32'(got()),     32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_quiet%0d", k), 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        // Recovery after the abort.
        send(vecs[7], 1'b1);
        collect("recover");
        release_out("recover");

        check("scoreboard_empty", 32'(scb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
